// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared types and default widths for the memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } arb_gnt_t;

endpackage

`default_nettype wire

// File: rtl/mips_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mips_arb_watchdog : busy-cycle counter that expires after TIMEOUT cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_arb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic unused_w;
         assign unused_w = &{1'b0, clk, reset, clear_i, enable_i};
         assign expire_o = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q <= '0;
            end else if (clear_i) begin
               cnt_q <= '0;
            end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         // cnt_q counts completed busy cycles, so the TIMEOUT-th one expires
         assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter : shares one memory port between fetch and data stages
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mem_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_done,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_fetch,
   output logic                stall_mem,
   output logic                err_timeout
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

   arb_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic              err_q, err_d;
   logic [SW-1:0]     starve_q, starve_d;

   arb_gnt_t          gnt_w;
   logic              busy_w;
   logic              expire_w;
   logic              starved_w;

   assign busy_w    = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
   assign starved_w = if_req && (starve_q == SW'(STARVE_LIMIT));
   assign gnt_w     = (dm_req && !starved_w) ? GNT_D : GNT_I;

   mips_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (!busy_w),
      .enable_i (busy_w),
      .expire_o (expire_w)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      err_d       = err_q;
      starve_d    = starve_q;

      case (state_q)
         ARB_IDLE: begin
            if (!if_req) begin
               starve_d = '0;
            end
            if (dm_req || if_req) begin
               mem_req_d = 1'b1;
               if (gnt_w == GNT_D) begin
                  state_d     = ARB_BUSY_D;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  mem_be_d    = dm_be;
                  if (if_req && (starve_q != SW'(STARVE_LIMIT))) begin
                     starve_d = starve_q + 1'b1;
                  end
               end else begin
                  state_d     = ARB_BUSY_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
                  starve_d    = '0;
               end
            end
         end

         ARB_BUSY_I, ARB_BUSY_D: begin
            // An ack landing on the expiry cycle is a normal completion
            if (mem_ack || expire_w) begin
               state_d   = ARB_RESP;
               mem_req_d = 1'b0;
               if (!mem_ack) begin
                  err_d = 1'b1;
               end
               if (state_q == ARB_BUSY_D) begin
                  dm_done_d  = 1'b1;
                  dm_rdata_d = mem_ack ? mem_rdata : '0;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_ack ? mem_rdata : '0;
               end
            end
         end

         ARB_RESP: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         err_q       <= 1'b0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign if_done     = if_done_q;
   assign dm_done     = dm_done_q;
   assign err_timeout = err_q;
   assign stall_fetch = if_req & ~if_done_q;
   assign stall_mem   = dm_req & ~dm_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter : directed + randomized transaction-level check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_mem_arbiter;

   localparam int SL = 4;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_be;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        if_done, dm_done, mem_req, mem_we;
   logic        stall_fetch, stall_mem, err_timeout;

   always #5 clk = ~clk;

   mips_mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (SL),
      .TIMEOUT      (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_done     (if_done),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_be       (dm_be),
      .dm_rdata    (dm_rdata),
      .dm_done     (dm_done),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .stall_fetch (stall_fetch),
      .stall_mem   (stall_mem),
      .err_timeout (err_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model: pending requests, starvation tally, sticky error, last data
   bit          if_pend, dm_pend, dwe;
   logic [31:0] ia, da, dwd;
   logic [3:0]  dbe;
   int          sc;
   bit          err_exp;
   logic [31:0] exp_if_rd, exp_dm_rd;
   bit          obs_gd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      if_req   = if_pend;
      if_addr  = ia;
      dm_req   = dm_pend;
      dm_we    = dwe;
      dm_addr  = da;
      dm_wdata = dwd;
      dm_be    = dbe;
   endtask

   task automatic new_reqs();
      if (!if_pend && ($urandom_range(0, 99) < 60)) begin
         if_pend = 1'b1;
         ia      = {$urandom} & 32'hFFFF_FFFC;
      end
      if (!dm_pend && ($urandom_range(0, 99) < 60)) begin
         dm_pend = 1'b1;
         dwe     = 1'($urandom_range(0, 1));
         da      = $urandom;
         dwd     = $urandom;
         dbe     = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic set_load(input logic [31:0] a);
      dm_pend = 1'b1; dwe = 1'b0; da = a; dwd = 32'h0; dbe = 4'hF;
   endtask

   // One arbitration round starting in an idle cycle; lat = busy cycle of the
   // ack (1..TO), or 0 for no ack at all.
   task automatic round(input int lat, input bit gen);
      bit          gd;
      logic [31:0] rd, expd;
      apply();
      #1;
      if (!if_pend && !dm_pend) begin
         sc = 0;
         if ($urandom_range(0, 1) == 1) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
         end
         step();
         mem_ack = 1'b0;
         #2;
         chk("idle mem_req", 32'(mem_req), 0);
         chk("idle if_done", 32'(if_done), 0);
         chk("idle dm_done", 32'(dm_done), 0);
         chk("idle if_rdata", if_rdata, exp_if_rd);
         chk("idle dm_rdata", dm_rdata, exp_dm_rd);
         if (gen) new_reqs();
         return;
      end

      gd = dm_pend && !(if_pend && sc == SL);
      if (!if_pend)  sc = 0;
      else if (gd)   sc = (sc < SL) ? sc + 1 : sc;
      else           sc = 0;

      chk("arb stall_fetch", 32'(stall_fetch), 32'(if_pend));
      chk("arb stall_mem", 32'(stall_mem), 32'(dm_pend));
      chk("arb mem_req", 32'(mem_req), 0);
      rd = $urandom;

      step();
      chk("gnt mem_req", 32'(mem_req), 1);
      chk("gnt mem_we", 32'(mem_we), gd ? 32'(dwe) : 0);
      chk("gnt mem_addr", mem_addr, gd ? da : ia);
      chk("gnt mem_be", 32'(mem_be), gd ? 32'(dbe) : 32'hF);
      if (gd) chk("gnt mem_wdata", mem_wdata, dwd);

      for (int k = 1; k <= TO; k++) begin
         if (k == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
         end
         #2;
         chk("busy mem_req", 32'(mem_req), 1);
         chk("busy if_done", 32'(if_done), 0);
         chk("busy dm_done", 32'(dm_done), 0);
         chk("busy stall_fetch", 32'(stall_fetch), 32'(if_pend));
         chk("busy stall_mem", 32'(stall_mem), 32'(dm_pend));
         if (k == lat || k == TO) break;
         step();
      end

      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      expd      = (lat != 0) ? rd : 32'h0;
      if (lat == 0) err_exp = 1'b1;
      #2;
      obs_gd = dm_done;
      chk("resp if_done", 32'(if_done), gd ? 0 : 1);
      chk("resp dm_done", 32'(dm_done), gd ? 1 : 0);
      if (gd) begin
         exp_dm_rd = expd;
         chk("resp dm_rdata", dm_rdata, exp_dm_rd);
      end else begin
         exp_if_rd = expd;
         chk("resp if_rdata", if_rdata, exp_if_rd);
      end
      chk("resp mem_req", 32'(mem_req), 0);
      chk("resp err_timeout", 32'(err_timeout), 32'(err_exp));
      chk("resp stall_fetch", 32'(stall_fetch), gd ? 32'(if_pend) : 0);
      chk("resp stall_mem", 32'(stall_mem), gd ? 0 : 32'(dm_pend));
      if (gd) dm_pend = 1'b0;
      else    if_pend = 1'b0;
      if (gen) new_reqs();
      apply();

      step();
      #2;
      chk("post if_done", 32'(if_done), 0);
      chk("post dm_done", 32'(dm_done), 0);
   endtask

   initial begin
      int    lat;
      int    r;
      bit    seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      reset     = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if_pend = 0; dm_pend = 0; dwe = 0; ia = 0; da = 0; dwd = 0; dbe = 0;
      sc = 0; err_exp = 0; exp_if_rd = 0; exp_dm_rd = 0;
      apply();
      step(); step();
      #2;
      chk("rst mem_req", 32'(mem_req), 0);
      chk("rst mem_we", 32'(mem_we), 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst mem_be", 32'(mem_be), 0);
      chk("rst if_rdata", if_rdata, 0);
      chk("rst dm_rdata", dm_rdata, 0);
      chk("rst done", {30'h0, if_done, dm_done}, 0);
      chk("rst err", 32'(err_timeout), 0);
      step();
      reset = 1'b0;

      // single fetch, ack on second busy cycle
      if_pend = 1'b1; ia = 32'h400;
      round(2, 0);
      chk("t1 if_rdata", if_rdata, 32'h2402000a ^ 32'h2402000a ^ exp_if_rd);

      // simultaneous store and fetch: data first, then fetch
      if_pend = 1'b1; ia = 32'h404;
      dm_pend = 1'b1; dwe = 1'b1; da = 32'h10; dwd = 32'hdeadbeef; dbe = 4'hF;
      round(1, 0);
      chk("t2 first gnt", 32'(obs_gd), 1);
      round(1, 0);
      chk("t2 second gnt", 32'(obs_gd), 0);

      // starvation guard: fetch held across back-to-back loads
      if_pend = 1'b1; ia = 32'h408;
      for (int i = 0; i < 6; i++) begin
         if (!dm_pend && i < 5) set_load(32'h100 + 32'(i * 4));
         round(1, 0);
         chk("t3 gnt seq", 32'(obs_gd), 32'(seq[i]));
      end

      // ack on the timeout cycle is a normal completion
      set_load(32'h200);
      round(TO, 0);
      chk("t6 err clear", 32'(err_timeout), 0);

      // no ack: abort with zero data and sticky error
      set_load(32'h204);
      round(0, 0);
      chk("t4 dm_rdata", dm_rdata, 0);
      round(0, 0);
      chk("t4 err sticky", 32'(err_timeout), 1);

      // reset during a data access, then a stale ack
      set_load(32'h208);
      apply();
      #1;
      step();
      #2;
      reset   = 1'b1;
      dm_pend = 1'b0;
      apply();
      #1;
      chk("t5 mem_req", 32'(mem_req), 0);
      chk("t5 dm_done", 32'(dm_done), 0);
      step();
      reset = 1'b0;
      sc = 0; err_exp = 0; exp_if_rd = 0; exp_dm_rd = 0;
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h55aa55aa;
      step();
      mem_ack = 1'b0;
      #2;
      chk("t5 stale dm_done", 32'(dm_done), 0);
      chk("t5 stale mem_req", 32'(mem_req), 0);
      chk("t5 stale dm_rdata", dm_rdata, 0);
      chk("t5 err", 32'(err_timeout), 0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      lat = 0;
         else if (r == 1) lat = TO;
         else             lat = $urandom_range(1, 4);
         round(lat, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
